// File: rtl/ahb_timer.sv
// ahb_timer: AHB-Lite slave exposing a 32-bit down-counting timer with reload and a level IRQ.
// Define AHB_TIMER_WAIT_EN to insert one wait state on reads (HRDATA then comes from a register).
module ahb_timer (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        IRQ
);
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic        dp_valid_q;
    logic        dp_write_q;
    logic [1:0]  dp_addr_q;

    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        ie_q, ie_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;

    logic        addr_phase;
    logic        wr_dp;
    logic        rd_dp;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        expire;
    logic [31:0] reg_rdata;
    logic        unused_bits;

    assign addr_phase = HSEL & HREADY & HTRANS[1];
    assign wr_dp      = dp_valid_q & dp_write_q;
    assign rd_dp      = dp_valid_q & ~dp_write_q;
    assign wr_ctrl    = wr_dp & (dp_addr_q == ADDR_CTRL);
    assign wr_load    = wr_dp & (dp_addr_q == ADDR_LOAD);
    assign wr_count   = wr_dp & (dp_addr_q == ADDR_COUNT);
    assign wr_status  = wr_dp & (dp_addr_q == ADDR_STATUS);
    assign expire     = en_q & (count_q == 32'd0);
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

    always_comb begin
        reg_rdata = 32'd0;
        case (dp_addr_q)
            ADDR_CTRL:   reg_rdata = {29'd0, ie_q, reload_q, en_q};
            ADDR_LOAD:   reg_rdata = load_q;
            ADDR_COUNT:  reg_rdata = count_q;
            ADDR_STATUS: reg_rdata = {31'd0, exp_q};
            default:     reg_rdata = 32'd0;
        endcase
    end

    // Timer behaviour first, then bus writes override it; expiry overrides the W1C clear.
    always_comb begin
        en_d     = en_q;
        reload_d = reload_q;
        ie_d     = ie_q;
        load_d   = load_q;
        count_d  = count_q;
        exp_d    = exp_q;

        if (en_q) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (reload_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_status && HWDATA[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end

        if (wr_load) begin
            load_d = HWDATA;
        end
        if (wr_count) begin
            count_d = HWDATA;
        end
        if (wr_ctrl) begin
            en_d     = HWDATA[0];
            reload_d = HWDATA[1];
            ie_d     = HWDATA[2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            exp_q      <= 1'b0;
        end else begin
            // A stalled data phase keeps its captured address until HREADY rises.
            if (HREADY) begin
                dp_valid_q <= addr_phase;
                dp_write_q <= HWRITE;
                dp_addr_q  <= HADDR[3:2];
            end
            en_q     <= en_d;
            reload_q <= reload_d;
            ie_q     <= ie_d;
            load_q   <= load_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
        end
    end

`ifdef AHB_TIMER_WAIT_EN
    logic        rd_wait_q;
    logic [31:0] rdata_q;

    // First read data cycle stalls and captures the register; second cycle presents it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_wait_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            rd_wait_q <= rd_dp & ~rd_wait_q;
            if (rd_dp && !rd_wait_q) begin
                rdata_q <= reg_rdata;
            end
        end
    end

    assign HREADYOUT = ~(rd_dp & ~rd_wait_q);
    assign HRDATA    = (rd_dp & rd_wait_q) ? rdata_q : 32'd0;
`else
    assign HREADYOUT = 1'b1;
    assign HRDATA    = rd_dp ? reg_rdata : 32'd0;
`endif

    assign HRESP = 1'b0;
    assign IRQ   = exp_q & ie_q;

endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: directed bench for ahb_timer; read expectations are queued at issue and checked at completion.
// Works with or without AHB_TIMER_WAIT_EN defined.
module tb_ahb_timer;
`ifdef AHB_TIMER_WAIT_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        IRQ;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    ahb_timer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .IRQ       (IRQ)
    );

    // Only slave on the bus, so the bus-wide ready follows this slave.
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock; a queued read completes in the cycle where HREADYOUT is high.
    task automatic tick();
        if (exp_q.size() != 0 && HREADYOUT === 1'b1) begin
            check(tag_q.pop_front(), HRDATA, exp_q.pop_front());
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] a, input logic [31:0] wd,
                         input logic [31:0] expd, input string tag);
        int n = 0;
        $display("xfer %s %s addr=%0d wdata=%h", w ? "WR" : "RD", tag, a, wd);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = {28'd0, a, 2'b00};
        HWRITE = w;
        while (HREADYOUT !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (n == 8) check({tag, "_stall"}, {31'd0, HREADYOUT}, 32'd1);
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = wd;
        if (!w) begin
            exp_q.push_back(expd);
            tag_q.push_back(tag);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 8) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // COUNT seen k cycles after LOAD=5, RELOAD=1 is enabled with COUNT=0.
    function automatic logic [31:0] count_at(input int k);
        if (k == 0) return 32'd0;
        return 32'(5 - ((k - 1) % 6));
    endfunction

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = 32'd0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HWDATA  = 32'd0;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        issue(1'b0, A_CTRL,   32'd0, 32'd0, "init_ctrl");
        issue(1'b0, A_LOAD,   32'd0, 32'd0, "init_load");
        issue(1'b0, A_COUNT,  32'd0, 32'd0, "init_count");
        issue(1'b0, A_STATUS, 32'd0, 32'd0, "init_status");
        drain();

        // Periodic reload: LOAD=5, CTRL=EN|RELOAD, COUNT sampled by back-to-back reads
        issue(1'b1, A_LOAD, 32'd5, 32'd0, "t1_load");
        issue(1'b1, A_CTRL, 32'd3, 32'd0, "t1_ctrl");
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, A_COUNT, 32'd0, count_at(i * (1 + WS)), $sformatf("t1_count%0d", i));
        end
        drain();
        issue(1'b0, A_STATUS, 32'd0, 32'd1, "t1_exp_set");
        issue(1'b0, A_CTRL,   32'd0, 32'd3, "t1_en_kept");
        issue(1'b1, A_CTRL,   32'd0, 32'd0, "t1_stop");
        issue(1'b1, A_STATUS, 32'd1, 32'd0, "t1_w1c");
        issue(1'b0, A_STATUS, 32'd0, 32'd0, "t1_exp_clr");
        drain();

        // One-shot with interrupt: COUNT=2, CTRL=EN|IE
        issue(1'b1, A_COUNT, 32'd2, 32'd0, "t2_count");
        issue(1'b1, A_CTRL,  32'd5, 32'd0, "t2_ctrl");
        tick();
        check("t2_irq_s0", {31'd0, IRQ}, 32'd0);
        tick();
        tick();
        check("t2_irq_s2", {31'd0, IRQ}, 32'd0);
        tick();
        check("t2_irq_s3", {31'd0, IRQ}, 32'd1);
        issue(1'b0, A_CTRL,  32'd0, 32'd4, "t2_en_autoclr");
        issue(1'b0, A_COUNT, 32'd0, 32'd0, "t2_count_held");
        drain();
        issue(1'b1, A_STATUS, 32'd1, 32'd0, "t2_w1c");
        check("t2_irq_before_w1c", {31'd0, IRQ}, 32'd1);
        tick();
        check("t2_irq_after_w1c", {31'd0, IRQ}, 32'd0);
        check("t2_hresp", {31'd0, HRESP}, 32'd0);

        // Back-to-back write then read of LOAD
        issue(1'b1, A_LOAD, 32'hA5A5_A5A5, 32'd0, "t3_load_wr");
        issue(1'b0, A_LOAD, 32'd0, 32'hA5A5_A5A5, "t3_load_rd");
        drain();

        // IDLE and unselected transfers must not write
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = {28'd0, A_LOAD, 2'b00};
        $display("xfer IDLE write attempt");
        tick();
        HWDATA = 32'hDEAD_BEEF;
        HSEL = 1'b0; HTRANS = 2'b10;
        $display("xfer unselected write attempt");
        tick();
        HWDATA = 32'h1234_5678;
        HTRANS = 2'b00; HWRITE = 1'b0;
        check("t4_idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        tick();
        issue(1'b0, A_LOAD, 32'd0, 32'hA5A5_A5A5, "t4_load_unchanged");
        drain();

        // COUNT write beats the same-cycle decrement
        issue(1'b1, A_COUNT, 32'd50, 32'd0, "t5_count");
        issue(1'b1, A_CTRL, 32'd1, 32'd0, "t5_ctrl");
        tick();
        tick();
        tick();
        issue(1'b1, A_COUNT, 32'h100, 32'd0, "t5_count_wr");
        issue(1'b0, A_COUNT, 32'd0, 32'h100, "t5_count_rd");
        drain();
        issue(1'b1, A_CTRL, 32'd0, 32'd0, "t5_stop");

        // Expiry beats a coincident W1C
        issue(1'b1, A_STATUS, 32'd1, 32'd0, "t6_preclear");
        issue(1'b1, A_COUNT, 32'd0, 32'd0, "t6_count0");
        issue(1'b1, A_CTRL, 32'd1, 32'd0, "t6_ctrl");
        issue(1'b1, A_STATUS, 32'd1, 32'd0, "t6_w1c_at_expiry");
        issue(1'b0, A_STATUS, 32'd0, 32'd1, "t6_exp_kept");
        issue(1'b0, A_CTRL, 32'd0, 32'd0, "t6_en_autoclr");
        issue(1'b1, A_STATUS, 32'd1, 32'd0, "t6_w1c");
        issue(1'b0, A_STATUS, 32'd0, 32'd0, "t6_exp_clr");
        drain();

        // Read CTRL=7; one wait state only when the wait option is built in
        issue(1'b1, A_CTRL, 32'd7, 32'd0, "t7_ctrl_wr");
        issue(1'b0, A_CTRL, 32'd0, 32'd7, "t7_ctrl_rd");
        check("t7_first_dp_hreadyout", {31'd0, HREADYOUT}, (WS == 1) ? 32'd0 : 32'd1);
        drain();
        check("t7_irq", {31'd0, IRQ}, 32'd1);

        // Reset mid-count and mid-read
        issue(1'b0, A_COUNT, 32'd0, 32'd0, "t8_read_dropped");
        #2;
        HRESETn = 1'b0;
        #1;
        exp_q.delete();
        tag_q.delete();
        check("t8_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("t8_rst_hrdata", HRDATA, 32'd0);
        check("t8_rst_irq", {31'd0, IRQ}, 32'd0);
        check("t8_rst_hresp", {31'd0, HRESP}, 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        issue(1'b0, A_COUNT,  32'd0, 32'd0, "t8_count");
        issue(1'b0, A_CTRL,   32'd0, 32'd0, "t8_ctrl");
        issue(1'b0, A_LOAD,   32'd0, 32'd0, "t8_load");
        issue(1'b0, A_STATUS, 32'd0, 32'd0, "t8_status");
        drain();
        check("t8_irq_after", {31'd0, IRQ}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
